// File: rtl/systolic_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_pkg
// Purpose  : Shared types and constants for the brightness systolic array
//            datapath (RAM loader, skew feeder, 4x4 array).
// Contents : feeder_state_t  - skew feeder control states
//            PE_DATA_WIDTH   - width of one processing-element word
//            ARRAY_DEPTH     - number of array rows (lanes)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

   localparam int PE_DATA_WIDTH = 16;
   localparam int ARRAY_DEPTH   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      DRAIN   = 2'd2,
      DONE_ST = 2'd3
   } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_skew_feeder_vec_fifo.sv
//------------------------------------------------------------------------------
// Module   : vec_fifo
// Purpose  : Small synchronous FIFO holding whole lane vectors. Head word is
//            presented combinationally on rd_data. A push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            push, wr_data       - write request and data
//            pop                 - consume head entry
//            rd_data             - head entry
//            full, empty, count  - occupancy status
// Params   : WIDTH      - vector width in bits
//            FIFO_DEPTH - number of entries, power of two, >= 2
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vec_fifo #(
   parameter int WIDTH      = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   import systolic_pkg::*;

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_wr_en;
   logic             w_rd_en;

   assign w_rd_en = pop && !empty;
   assign w_wr_en = push && (!full || w_rd_en);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign count   = r_wr_ptr - r_rd_ptr;
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : systolic_skew_feeder
// Purpose  : Buffers DEPTH-lane pixel vectors from the RAM loader and feeds the
//            systolic array rows with diagonal skew (lane i lags lane 0 by i
//            array advances). Absorbs array stalls and drains the skew
//            pipeline with bubbles once the source reports completion.
// Ports    : clk, reset    - clock, asynchronous active-high reset
//            start         - one-cycle pulse, accepted only when idle
//            in_data       - packed input vector, lane 0 in LSBs
//            in_valid      - push in_data this cycle
//            src_done      - one-cycle pulse, no more vectors follow
//            array_ready   - array advances this cycle
//            row_data      - skewed lane outputs, lane 0 in LSBs
//            row_valid     - per-lane valid
//            busy          - controller not idle
//            overflow      - sticky, a push was dropped
//            flush_done    - one-cycle pulse at end of drain
//            drop_count    - saturating dropped-push counter (optional)
// Config   : SKEW_DROP_COUNT_EN - when defined, adds the drop_count port.
// Params   : PE_DATA_WIDTH, DEPTH (>= 2), FIFO_DEPTH (power of two, >= 2)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_skew_feeder #(
   parameter int PE_DATA_WIDTH = systolic_pkg::PE_DATA_WIDTH,
   parameter int DEPTH         = systolic_pkg::ARRAY_DEPTH,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [PE_DATA_WIDTH*DEPTH-1:0] in_data,
   input  logic                           in_valid,
   input  logic                           src_done,
   input  logic                           array_ready,
   output logic [PE_DATA_WIDTH*DEPTH-1:0] row_data,
   output logic [DEPTH-1:0]               row_valid,
   output logic                           busy,
   output logic                           overflow,
   output logic                           flush_done
`ifdef SKEW_DROP_COUNT_EN
   ,
   output logic [7:0]                     drop_count
`endif
);
   import systolic_pkg::*;

   localparam int                VW  = PE_DATA_WIDTH * DEPTH;
   localparam int                FAW = $clog2(FIFO_DEPTH);
   localparam int                CW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]     C_DRAIN_LAST = CW'(DEPTH - 2);
   localparam logic [FAW:0]      C_ONE_ENTRY  = (FAW+1)'(1);

   feeder_state_t   r_state;
   logic            r_busy;
   logic            r_flush_done;
   logic            r_src_done;
   logic            r_overflow;
   logic [CW-1:0]   r_drain_cnt;

   logic [VW-1:0]   w_fifo_rd;
   logic            w_full;
   logic            w_empty;
   logic [FAW:0]    w_count;

   logic            w_in_stream;
   logic            w_advance;
   logic            w_pop;
   logic            w_push_req;
   logic            w_push;
   logic            w_drop;
   logic            w_start_ok;
   logic            w_src_seen;
   logic            w_empty_next;

   assign w_in_stream = (r_state == STREAM);
   assign w_advance   = array_ready && (r_state == STREAM || r_state == DRAIN);
   assign w_pop       = w_advance && w_in_stream && !w_empty;
   assign w_push_req  = in_valid && w_in_stream;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_drop      = w_push_req && w_full && !w_pop;
   assign w_start_ok  = start && (r_state == IDLE);
   assign w_src_seen  = r_src_done || src_done;
   // Leave STREAM on the same edge that pops the last vector, so DRAIN needs
   // exactly DEPTH-1 further advances to push that vector out of lane DEPTH-1.
   assign w_empty_next = !w_push && (w_empty || (w_pop && w_count == C_ONE_ENTRY));

   vec_fifo #(
      .WIDTH      (VW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (w_push),
      .wr_data (in_data),
      .pop     (w_pop),
      .rd_data (w_fifo_rd),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // Control FSM with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_flush_done <= 1'b0;
         r_src_done   <= 1'b0;
         r_drain_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= STREAM;
                  r_busy     <= 1'b1;
                  r_src_done <= 1'b0;
               end
            end
            STREAM: begin
               if (src_done) r_src_done <= 1'b1;
               if (w_src_seen && w_empty_next) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (w_advance) begin
                  if (r_drain_cnt == C_DRAIN_LAST) begin
                     r_state      <= DONE_ST;
                     r_flush_done <= 1'b1;
                  end else begin
                     r_drain_cnt <= r_drain_cnt + 1'b1;
                  end
               end
            end
            DONE_ST: begin
               r_state      <= IDLE;
               r_busy       <= 1'b0;
               r_flush_done <= 1'b0;
               r_src_done   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_start_ok) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef SKEW_DROP_COUNT_EN
   logic [7:0] r_drop_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_count <= '0;
      end else if (w_start_ok) begin
         r_drop_count <= '0;
      end else if (w_drop && r_drop_count != 8'hFF) begin
         r_drop_count <= r_drop_count + 8'd1;
      end
   end

   assign drop_count = r_drop_count;
`endif

   // Lane i is a chain of i+1 registers; the last one drives the row output.
   // Stage 0 takes the FIFO head on a pop, otherwise a zero-data bubble.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
      logic [PE_DATA_WIDTH-1:0] r_dat [0:gi];
      logic [gi:0]              r_vld;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int s = 0; s <= gi; s++) begin
               r_dat[s] <= '0;
            end
            r_vld <= '0;
         end else if (w_advance) begin
            r_dat[0] <= w_pop ? w_fifo_rd[gi*PE_DATA_WIDTH +: PE_DATA_WIDTH] : '0;
            r_vld[0] <= w_pop;
            for (int s = 1; s <= gi; s++) begin
               r_dat[s] <= r_dat[s-1];
               r_vld[s] <= r_vld[s-1];
            end
         end
      end

      assign row_data[gi*PE_DATA_WIDTH +: PE_DATA_WIDTH] = r_dat[gi];
      assign row_valid[gi]                               = r_vld[gi];
   end

   assign busy       = r_busy;
   assign overflow   = r_overflow;
   assign flush_done = r_flush_done;

endmodule

`default_nettype wire
